dram_write_scheduler: RTL and testbench
=======================================

Name: dram_write_scheduler

Overview:
- Sequences the 64-bit AXI DRAM write engine for multi-frame capture jobs.
- Accepts one job (base address, frame size, frame count). Issues one CONFIG transaction per frame into a ring of BUF_COUNT frame buffers.
- Snoops the AXI B channel to detect when each frame is committed to DRAM. Reports per-frame completion, job completion and error status to the host control logic.

Parameters:
- BUF_COUNT, 2, number of frame buffers in the ring (1..16); frame k lands in buffer k mod BUF_COUNT.
- NFRAMES_W, 16, width of the frame-count and frame-index fields.

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  asynchronous active-low reset
- START_VALID  in  1  job request
- START_READY  out  1  high only in IDLE
- START_BASE_ADDR  in  32  byte address of buffer 0
- START_FRAME_BYTES  in  32  bytes per frame; bits [6:0] ignored
- START_NFRAMES  in  NFRAMES_W  frames in the job
- WR_CONFIG_VALID  out  1  to writer CONFIG_VALID
- WR_CONFIG_READY  in  1  from writer CONFIG_READY
- WR_CONFIG_START_ADDR  out  32  frame start address
- WR_CONFIG_NBYTES  out  32  frame bytes, 128-aligned
- M_AXI_BVALID  in  1  snooped write response valid; the writer holds BREADY at 1
- M_AXI_BRESP  in  2  snooped response code
- FRAME_DONE  out  1  one-cycle pulse when all bursts of a frame have responded
- FRAME_IDX  out  NFRAMES_W  index of the frame reported by FRAME_DONE
- BUSY  out  1  high from job accept until DONE
- DONE  out  1  one-cycle pulse at job end
- ERROR  out  1  sticky; cleared on next job accept

Behaviour:
- Reset (asynchronous, ARESETN=0): all outputs 0 except START_READY=1; FSM returns to IDLE; all counters cleared. Reset mid-job abandons the job; no DONE pulse.
- Latch on accept: burst count BPF = START_FRAME_BYTES[31:7] (25 bits), FB = {BPF,7'b0}, base address, frame count. ERROR is cleared on the same edge.
- FSM states: IDLE, ISSUE, DRAIN, FINISH.
- IDLE: START_VALID && START_READY accepts the job and goes to ISSUE. Exceptions go straight to FINISH:
  - NFRAMES=0: FINISH, no error.
  - BPF=0: FINISH with ERROR=1, because the writer must never receive NBYTES<128.
- ISSUE: WR_CONFIG_VALID=1, WR_CONFIG_START_ADDR = base + (issue_idx mod BUF_COUNT)*FB (32-bit wrap), WR_CONFIG_NBYTES = FB.
  - VALID is held, with address and size stable, until WR_CONFIG_READY.
  - On the handshake, issue_idx increments. After the last frame, go to DRAIN; otherwise VALID drops for exactly one cycle, then re-asserts for the next frame.
  - The writer only raises READY when idle, so frame N+1 may be issued while frame N's B responses are outstanding.
- B tracking:
  - A 41-bit resp_cnt increments on every M_AXI_BVALID while BUSY.
  - A 41-bit frame_target starts at BPF and adds BPF after each reported frame.
  - When resp_cnt == frame_target: FRAME_DONE=1 the next cycle with FRAME_IDX = done_idx, then done_idx increments.
  - At most one frame completes per response, so no pulses are coalesced.
  - BVALID in the same cycle as a config handshake: both counters update independently.
- BRESP != 2'b00 on any BVALID sets ERROR. The job continues and is not aborted.
- DRAIN: stays until done_idx == NFRAMES, then goes to FINISH.
- FINISH: DONE=1 for one cycle, BUSY drops, returns to IDLE.
- BVALID arriving in IDLE is ignored (not counted) and does not set ERROR.
- START_VALID outside IDLE is not accepted, because START_READY=0.
- BUF_COUNT=1 gives the same address for every frame. For non-power-of-two BUF_COUNT, the buffer slot is kept as a wrapping counter, not a modulo operation.

Decomposition:
- Shared package: FSM state encoding, AXI_BURST_BYTES=128, BURST_SHIFT=7, BRESP_OKAY=2'b00.
- One sub-module: dram_bresp_tracker. It holds resp_cnt, frame_target and done_idx, and generates FRAME_DONE, FRAME_IDX and the error flag. The top level keeps the FSM and the address ring.

Test Plan:
- Base 0x1000_0000, 512 B, 3 frames, BUF_COUNT=2, writer READY after 4 B responses:
  - Required: configs at 0x1000_0000, 0x1000_0200, 0x1000_0000, each NBYTES=512.
  - Required: FRAME_DONE ×3 with IDX 0,1,2 after responses 4, 8 and 12; one DONE pulse; ERROR=0.
- FRAME_BYTES=0x7F, NFRAMES=1 -> no WR_CONFIG_VALID; DONE and ERROR=1 one cycle after accept.
- NFRAMES=0 -> DONE pulse, no config, ERROR=0. Then start a new valid job -> ERROR stays 0 and the job runs.
- FRAME_BYTES=0x1FF -> NBYTES=0x180; FRAME_DONE after 3 responses.
- Inject BRESP=2'b10 on the second response -> ERROR stays 1 through DONE; all frames are still issued and reported.
- Assert ARESETN=0 mid-DRAIN -> all outputs cleared asynchronously; START_READY=1 after release; a fresh job completes normally.

Source files
------------

// File: rtl/dram_write_scheduler_pkg.sv
// Shared definitions for the DRAM write scheduler slice.
//   - sched_state_t : job sequencing states
//   - AXI_BURST_BYTES / BURST_SHIFT : the writer moves data in 128-byte bursts
//   - BRESP_OKAY : the only write response code that is not an error
//   - BPF_W : width of the bursts-per-frame count (frame bytes without the burst offset)
package dram_write_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } sched_state_t;

    localparam int unsigned AXI_BURST_BYTES = 128;
    localparam int unsigned BURST_SHIFT     = 7;
    localparam logic [1:0]  BRESP_OKAY      = 2'b00;
    localparam int unsigned BPF_W           = 32 - BURST_SHIFT;

endpackage

// File: rtl/dram_write_scheduler_if.sv
// Signal bundle between the write scheduler and its surroundings
// (host job request, writer CONFIG channel, snooped AXI B channel, status).
//   master : the scheduler's view (drives START_READY, WR_CONFIG_*, status)
//   slave  : the environment's view (host, writer and AXI response snoop)
interface dram_write_scheduler_if #(
    parameter int NFRAMES_W = 16
);
    logic                 START_VALID;
    logic                 START_READY;
    logic [31:0]          START_BASE_ADDR;
    logic [31:0]          START_FRAME_BYTES;
    logic [NFRAMES_W-1:0] START_NFRAMES;

    logic                 WR_CONFIG_VALID;
    logic                 WR_CONFIG_READY;
    logic [31:0]          WR_CONFIG_START_ADDR;
    logic [31:0]          WR_CONFIG_NBYTES;

    logic                 M_AXI_BVALID;
    logic [1:0]           M_AXI_BRESP;

    logic                 FRAME_DONE;
    logic [NFRAMES_W-1:0] FRAME_IDX;
    logic                 BUSY;
    logic                 DONE;
    logic                 ERROR;

    modport master (
        input  START_VALID, START_BASE_ADDR, START_FRAME_BYTES, START_NFRAMES,
        output START_READY,
        output WR_CONFIG_VALID, WR_CONFIG_START_ADDR, WR_CONFIG_NBYTES,
        input  WR_CONFIG_READY,
        input  M_AXI_BVALID, M_AXI_BRESP,
        output FRAME_DONE, FRAME_IDX, BUSY, DONE, ERROR
    );

    modport slave (
        output START_VALID, START_BASE_ADDR, START_FRAME_BYTES, START_NFRAMES,
        input  START_READY,
        input  WR_CONFIG_VALID, WR_CONFIG_START_ADDR, WR_CONFIG_NBYTES,
        output WR_CONFIG_READY,
        output M_AXI_BVALID, M_AXI_BRESP,
        input  FRAME_DONE, FRAME_IDX, BUSY, DONE, ERROR
    );
endinterface

// File: rtl/dram_bresp_tracker.sv
// Watches the snooped AXI B channel and decides when each frame is committed.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   clear_i      : job accepted; reload counters (bpf_i carries the new burst count)
//   setErr_i     : job rejected for a zero burst count; ERROR starts set
//   count_i      : job in progress, B responses are counted
//   detect_i     : frame completion may be reported (ISSUE/DRAIN)
//   bpf_i        : bursts per frame
//   bvalid_i/bresp_i : snooped write response
//   frameDone_o/frameIdx_o : one-cycle completion pulse and its frame index
//   doneIdx_o    : number of frames reported so far
//   error_o      : sticky error flag
module dram_bresp_tracker
    import dram_write_scheduler_pkg::*;
#(
    parameter int NFRAMES_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_i,
    input  logic                 setErr_i,
    input  logic                 count_i,
    input  logic                 detect_i,
    input  logic [BPF_W-1:0]     bpf_i,
    input  logic                 bvalid_i,
    input  logic [1:0]           bresp_i,
    output logic                 frameDone_o,
    output logic [NFRAMES_W-1:0] frameIdx_o,
    output logic [NFRAMES_W-1:0] doneIdx_o,
    output logic                 error_o
);
    // Wide enough for every response of a maximal job.
    localparam int CNT_W = BPF_W + NFRAMES_W;

    logic [CNT_W-1:0]     respCnt_q, respCnt_d;
    logic [CNT_W-1:0]     frameTarget_q, frameTarget_d;
    logic [NFRAMES_W-1:0] doneIdx_q, doneIdx_d;
    logic [NFRAMES_W-1:0] frameIdx_q, frameIdx_d;
    logic                 frameDone_q, frameDone_d;
    logic                 error_q, error_d;
    logic                 hit;

    // Targets advance by one frame per report, so one response completes at most one frame.
    always_comb begin
        hit           = detect_i && (respCnt_q == frameTarget_q);
        respCnt_d     = respCnt_q;
        frameTarget_d = frameTarget_q;
        doneIdx_d     = doneIdx_q;
        frameIdx_d    = frameIdx_q;
        frameDone_d   = hit;
        error_d       = error_q;
        if (clear_i) begin
            respCnt_d     = '0;
            frameTarget_d = CNT_W'(bpf_i);
            doneIdx_d     = '0;
            error_d       = setErr_i;
        end else begin
            if (count_i && bvalid_i) begin
                respCnt_d = respCnt_q + CNT_W'(1);
                if (bresp_i != BRESP_OKAY) begin
                    error_d = 1'b1;
                end
            end
            if (hit) begin
                frameTarget_d = frameTarget_q + CNT_W'(bpf_i);
                doneIdx_d     = doneIdx_q + NFRAMES_W'(1);
                frameIdx_d    = doneIdx_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            respCnt_q     <= '0;
            frameTarget_q <= '0;
            doneIdx_q     <= '0;
            frameIdx_q    <= '0;
            frameDone_q   <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            respCnt_q     <= respCnt_d;
            frameTarget_q <= frameTarget_d;
            doneIdx_q     <= doneIdx_d;
            frameIdx_q    <= frameIdx_d;
            frameDone_q   <= frameDone_d;
            error_q       <= error_d;
        end
    end

    assign frameDone_o = frameDone_q;
    assign frameIdx_o  = frameIdx_q;
    assign doneIdx_o   = doneIdx_q;
    assign error_o     = error_q;

endmodule

// File: rtl/dram_write_scheduler.sv
// Sequences the 64-bit AXI DRAM writer for multi-frame capture jobs: one CONFIG
// per frame into a ring of BUF_COUNT buffers, frame completion from B responses.
// Ports:
//   ACLK, ARESETN : clock, asynchronous active-low reset
//   bus (master)  : START request, writer CONFIG channel, B snoop, FRAME_DONE/IDX,
//                   BUSY, DONE, ERROR
module dram_write_scheduler
    import dram_write_scheduler_pkg::*;
#(
    parameter int BUF_COUNT = 2,
    parameter int NFRAMES_W = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    dram_write_scheduler_if.master bus
);
    localparam int SLOT_W = (BUF_COUNT > 1) ? $clog2(BUF_COUNT) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(BUF_COUNT - 1);

    sched_state_t         state_q, state_d;
    logic [BPF_W-1:0]     bpf_q, bpf_d;
    logic [31:0]          base_q, base_d;
    logic [NFRAMES_W-1:0] nframes_q, nframes_d;
    logic [NFRAMES_W-1:0] issueIdx_q, issueIdx_d;
    logic [SLOT_W-1:0]    slot_q, slot_d;
    logic [31:0]          slotAddr_q, slotAddr_d;
    logic                 gap_q, gap_d;

    logic [BPF_W-1:0]     startBpf;
    logic [31:0]          frameBytes;
    logic                 cfgValid, cfgFire, lastIssue;
    logic                 trackClear, cfgErr;
    logic                 frameDone, errorFlag;
    logic [NFRAMES_W-1:0] frameIdx, doneIdx;
    logic                 unusedLowBytes;

    // The byte offset within a burst is dropped; only whole bursts are written.
    assign unusedLowBytes = ^bus.START_FRAME_BYTES[BURST_SHIFT-1:0];
    assign startBpf   = bus.START_FRAME_BYTES[31:BURST_SHIFT];
    assign frameBytes = {bpf_q, {BURST_SHIFT{1'b0}}};
    assign cfgValid   = (state_q == ISSUE) && !gap_q;
    assign cfgFire    = cfgValid && bus.WR_CONFIG_READY;
    assign lastIssue  = (issueIdx_q == nframes_q - NFRAMES_W'(1));

    // Next-state logic. The buffer slot is a wrapping counter with a running
    // address, so no multiply or modulo is needed for any BUF_COUNT.
    always_comb begin
        state_d    = state_q;
        bpf_d      = bpf_q;
        base_d     = base_q;
        nframes_d  = nframes_q;
        issueIdx_d = issueIdx_q;
        slot_d     = slot_q;
        slotAddr_d = slotAddr_q;
        gap_d      = 1'b0;
        trackClear = 1'b0;
        cfgErr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.START_VALID) begin
                    bpf_d      = startBpf;
                    base_d     = bus.START_BASE_ADDR;
                    nframes_d  = bus.START_NFRAMES;
                    issueIdx_d = '0;
                    slot_d     = '0;
                    slotAddr_d = bus.START_BASE_ADDR;
                    trackClear = 1'b1;
                    if (bus.START_NFRAMES == '0) begin
                        state_d = FINISH;
                    end else if (startBpf == '0) begin
                        // A sub-burst frame would hand the writer NBYTES < 128.
                        state_d = FINISH;
                        cfgErr  = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (cfgFire) begin
                    issueIdx_d = issueIdx_q + NFRAMES_W'(1);
                    if (slot_q == LAST_SLOT) begin
                        slot_d     = '0;
                        slotAddr_d = base_q;
                    end else begin
                        slot_d     = slot_q + SLOT_W'(1);
                        slotAddr_d = slotAddr_q + frameBytes;
                    end
                    if (lastIssue) begin
                        state_d = DRAIN;
                    end else begin
                        gap_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (doneIdx == nframes_q) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q    <= IDLE;
            bpf_q      <= '0;
            base_q     <= '0;
            nframes_q  <= '0;
            issueIdx_q <= '0;
            slot_q     <= '0;
            slotAddr_q <= '0;
            gap_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bpf_q      <= bpf_d;
            base_q     <= base_d;
            nframes_q  <= nframes_d;
            issueIdx_q <= issueIdx_d;
            slot_q     <= slot_d;
            slotAddr_q <= slotAddr_d;
            gap_q      <= gap_d;
        end
    end

    dram_bresp_tracker #(
        .NFRAMES_W (NFRAMES_W)
    ) u_tracker (
        .clk         (ACLK),
        .rst_n       (ARESETN),
        .clear_i     (trackClear),
        .setErr_i    (cfgErr),
        .count_i     (state_q != IDLE),
        .detect_i    ((state_q == ISSUE) || (state_q == DRAIN)),
        .bpf_i       (bpf_d),
        .bvalid_i    (bus.M_AXI_BVALID),
        .bresp_i     (bus.M_AXI_BRESP),
        .frameDone_o (frameDone),
        .frameIdx_o  (frameIdx),
        .doneIdx_o   (doneIdx),
        .error_o     (errorFlag)
    );

    assign bus.START_READY          = (state_q == IDLE);
    assign bus.WR_CONFIG_VALID      = cfgValid;
    assign bus.WR_CONFIG_START_ADDR = slotAddr_q;
    assign bus.WR_CONFIG_NBYTES     = frameBytes;
    assign bus.FRAME_DONE           = frameDone;
    assign bus.FRAME_IDX            = frameIdx;
    assign bus.BUSY                 = (state_q != IDLE);
    assign bus.DONE                 = (state_q == FINISH);
    assign bus.ERROR                = errorFlag;

endmodule

// File: tb/tb_dram_write_scheduler.sv
// Self-checking bench for dram_write_scheduler. A writer model accepts CONFIGs and
// returns one B response per burst; expected CONFIGs and frame completions are
// queued and compared as the DUT produces them.
module tb_dram_write_scheduler;
    localparam int BUFS = 2;
    localparam int NW   = 16;

    logic aclk = 1'b0;
    logic aresetn;
    always #5 aclk = ~aclk;

    dram_write_scheduler_if #(.NFRAMES_W(NW)) bus ();

    dram_write_scheduler #(
        .BUF_COUNT (BUFS),
        .NFRAMES_W (NW)
    ) dut (
        .ACLK    (aclk),
        .ARESETN (aresetn),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] nbytes;
    } cfg_t;

    typedef struct {
        logic [NW-1:0] idx;
        int            cyc;
    } frame_t;

    cfg_t   cfgQ[$];
    frame_t frameQ[$];
    cfg_t   cfgExp;
    frame_t frExp;
    frame_t frPush;

    int errCount   = 0;
    int checkCount = 0;
    int cyc        = 0;
    int doneCnt    = 0;
    int tbBpf      = 0;
    int tbErrAt    = 0;
    int extraReq   = 0;

    int  respLeft  = 0;
    int  respNum   = 0;
    int  extraDone = 0;
    logic hs;

    int waited;
    int doneBefore;
    int w;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    always @(posedge aclk) cyc <= cyc + 1;

    // Writer model: READY while idle; after each CONFIG it returns tbBpf responses.
    initial begin
        hs = 1'b0;
        bus.WR_CONFIG_READY = 1'b0;
        bus.M_AXI_BVALID    = 1'b0;
        bus.M_AXI_BRESP     = 2'b00;
        forever begin
            @(negedge aclk);
            hs = bus.WR_CONFIG_VALID && bus.WR_CONFIG_READY;
            if (bus.START_VALID && bus.START_READY) respNum = 0;
            @(posedge aclk);
            #1;
            bus.M_AXI_BVALID = 1'b0;
            bus.M_AXI_BRESP  = 2'b00;
            if (!aresetn) begin
                respLeft = 0;
                bus.WR_CONFIG_READY = 1'b0;
            end else begin
                if (hs) respLeft = tbBpf;
                if (respLeft > 0) begin
                    respNum++;
                    respLeft--;
                    bus.M_AXI_BVALID = 1'b1;
                    bus.M_AXI_BRESP  = (respNum == tbErrAt) ? 2'b10 : 2'b00;
                    if (tbBpf > 0 && (respNum % tbBpf) == 0) begin
                        frPush.idx = NW'(respNum / tbBpf - 1);
                        frPush.cyc = cyc;
                        frameQ.push_back(frPush);
                    end
                end else if (extraDone < extraReq) begin
                    extraDone++;
                    bus.M_AXI_BVALID = 1'b1;
                    bus.M_AXI_BRESP  = 2'b10;
                end
                bus.WR_CONFIG_READY = (respLeft == 0);
            end
        end
    end

    // Scoreboard monitor: compares each CONFIG handshake and FRAME_DONE pulse.
    always @(negedge aclk) begin
        if (!aresetn) begin
            cfgQ.delete();
            frameQ.delete();
        end else begin
            if (bus.WR_CONFIG_VALID && bus.WR_CONFIG_READY) begin
                if (cfgQ.size() == 0) begin
                    checkOutput("cfg_unexpected", 64'(bus.WR_CONFIG_START_ADDR), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    cfgExp = cfgQ.pop_front();
                    checkOutput("cfg_addr", 64'(bus.WR_CONFIG_START_ADDR), 64'(cfgExp.addr));
                    checkOutput("cfg_nbytes", 64'(bus.WR_CONFIG_NBYTES), 64'(cfgExp.nbytes));
                end
            end
            if (bus.FRAME_DONE) begin
                if (frameQ.size() == 0) begin
                    checkOutput("frame_unexpected", 64'(bus.FRAME_IDX), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    frExp = frameQ.pop_front();
                    checkOutput("frame_idx", 64'(bus.FRAME_IDX), 64'(frExp.idx));
                    checkOutput("frame_latency", 64'(cyc - frExp.cyc), 64'd2);
                end
            end
            if (bus.DONE) doneCnt++;
        end
    end

    // Queues the expected CONFIGs for a job and presents it for one accept cycle.
    task automatic applyStimulus(input logic [31:0] base, input logic [31:0] bytes, input int n, input int errAt);
        logic [31:0] fb;
        fb      = bytes & 32'hFFFF_FF80;
        tbBpf   = int'(bytes >> 7);
        tbErrAt = errAt;
        if (tbBpf > 0) begin
            for (int k = 0; k < n; k++) begin
                cfg_t c;
                c.addr   = base + fb * 32'(k % BUFS);
                c.nbytes = fb;
                cfgQ.push_back(c);
            end
        end
        doneBefore = doneCnt;
        @(posedge aclk);
        #1;
        bus.START_VALID       = 1'b1;
        bus.START_BASE_ADDR   = base;
        bus.START_FRAME_BYTES = bytes;
        bus.START_NFRAMES     = NW'(n);
        @(posedge aclk);
        #1;
        bus.START_VALID = 1'b0;
    endtask

    // Waits (bounded) for DONE and checks the end-of-job state.
    task automatic waitDone(input int maxCyc, input logic expErr, output int cycles);
        cycles = 0;
        do begin
            @(negedge aclk);
            cycles++;
            if (cycles == 1) begin
                checkOutput("busy_after_accept", 64'(bus.BUSY), 64'd1);
                checkOutput("ready_after_accept", 64'(bus.START_READY), 64'd0);
            end
        end while (!bus.DONE && cycles < maxCyc);
        if (!bus.DONE) begin
            checkOutput("done_timeout", 64'd0, 64'd1);
        end else begin
            checkOutput("error_at_done", 64'(bus.ERROR), 64'(expErr));
        end
        @(negedge aclk);
        checkOutput("busy_after_done", 64'(bus.BUSY), 64'd0);
        checkOutput("ready_after_done", 64'(bus.START_READY), 64'd1);
        checkOutput("done_single_pulse", 64'(bus.DONE), 64'd0);
        checkOutput("done_count", 64'(doneCnt), 64'(doneBefore + 1));
        checkOutput("cfg_pending", 64'(cfgQ.size()), 64'd0);
        checkOutput("frames_pending", 64'(frameQ.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        aresetn               = 1'b0;
        bus.START_VALID       = 1'b0;
        bus.START_BASE_ADDR   = '0;
        bus.START_FRAME_BYTES = '0;
        bus.START_NFRAMES     = '0;
        #2;
        checkOutput("rst_start_ready", 64'(bus.START_READY), 64'd1);
        checkOutput("rst_busy", 64'(bus.BUSY), 64'd0);
        checkOutput("rst_done", 64'(bus.DONE), 64'd0);
        checkOutput("rst_error", 64'(bus.ERROR), 64'd0);
        checkOutput("rst_cfg_valid", 64'(bus.WR_CONFIG_VALID), 64'd0);
        checkOutput("rst_frame_done", 64'(bus.FRAME_DONE), 64'd0);
        checkOutput("rst_frame_idx", 64'(bus.FRAME_IDX), 64'd0);
        repeat (3) @(posedge aclk);
        #2 aresetn = 1'b1;

        $display("[TB] job: 3 frames of 512 B");
        applyStimulus(32'h1000_0000, 32'd512, 3, 0);
        waitDone(400, 1'b0, waited);

        $display("[TB] job: sub-burst frame size");
        applyStimulus(32'h0000_0000, 32'h7F, 1, 0);
        waitDone(10, 1'b1, waited);
        checkOutput("bpf0_latency", 64'(waited), 64'd1);

        $display("[TB] job: zero frames");
        applyStimulus(32'h5000_0000, 32'd512, 0, 0);
        waitDone(10, 1'b0, waited);
        checkOutput("nframes0_latency", 64'(waited), 64'd1);

        $display("[TB] idle B responses");
        extraReq += 3;
        repeat (6) @(negedge aclk);
        checkOutput("idle_bvalid_error", 64'(bus.ERROR), 64'd0);
        checkOutput("idle_bvalid_busy", 64'(bus.BUSY), 64'd0);

        $display("[TB] job: 0x1FF bytes, 2 frames");
        applyStimulus(32'h2000_0040, 32'h1FF, 2, 0);
        waitDone(200, 1'b0, waited);

        $display("[TB] job: error response, address wrap");
        applyStimulus(32'hFFFF_FF00, 32'd256, 3, 2);
        waitDone(200, 1'b1, waited);

        $display("[TB] job: reset during drain");
        doneBefore = doneCnt;
        applyStimulus(32'h3000_0000, 32'd512, 2, 2);
        w = 0;
        while (cfgQ.size() != 0 && w < 200) begin
            @(negedge aclk);
            w++;
        end
        checkOutput("drain_issue_timeout", 64'(cfgQ.size()), 64'd0);
        repeat (3) @(negedge aclk);
        checkOutput("drain_error_set", 64'(bus.ERROR), 64'd1);
        checkOutput("drain_busy", 64'(bus.BUSY), 64'd1);
        @(posedge aclk);
        #2 aresetn = 1'b0;
        #1;
        checkOutput("async_rst_busy", 64'(bus.BUSY), 64'd0);
        checkOutput("async_rst_ready", 64'(bus.START_READY), 64'd1);
        checkOutput("async_rst_error", 64'(bus.ERROR), 64'd0);
        checkOutput("async_rst_cfg_valid", 64'(bus.WR_CONFIG_VALID), 64'd0);
        checkOutput("async_rst_nbytes", 64'(bus.WR_CONFIG_NBYTES), 64'd0);
        checkOutput("async_rst_done", 64'(bus.DONE), 64'd0);
        repeat (2) @(posedge aclk);
        #2 aresetn = 1'b1;
        repeat (2) @(negedge aclk);
        checkOutput("post_rst_ready", 64'(bus.START_READY), 64'd1);
        checkOutput("post_rst_no_done", 64'(doneCnt), 64'(doneBefore));

        $display("[TB] job: fresh job after reset");
        applyStimulus(32'h4000_0000, 32'd256, 3, 0);
        waitDone(200, 1'b0, waited);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
